rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
// PURPOSE
//   Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.
//   Each input channel is a producer. The block supports two modes:
//     - fixed mode: a select input picks the channel.
//     - round-robin mode: grants rotate fairly among valid channels.
//   One output register drives a single consumer, for example the operand bus of
//   the expression solver datapath.
// PARAMETERS
//   WIDTH     16  data width per channel
//   CHANNELS  4   number of input channels (>=2)
//   SEL_W     2   select / channel-index width, = $clog2(CHANNELS)
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   rr_en      in   1               0 = fixed select mode, 1 = round-robin mode
//   select     in   SEL_W           channel index used when rr_en = 0
//   in_data    in   CHANNELS*WIDTH  flattened inputs; channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS        per-channel data valid
//   in_ready   out  CHANNELS        per-channel accept; at most one bit high per cycle
//   out_data   out  WIDTH           registered selected word
//   out_chan   out  SEL_W           index of the channel that supplied out_data
//   out_valid  out  1               out_data holds an unconsumed word
//   out_ready  in   1               consumer accepts out_data this cycle
// BEHAVIOUR
//   Reset (rst_n low, asynchronous):
//     - out_valid = 0, out_data = 0, out_chan = 0.
//     - Round-robin pointer last = CHANNELS-1, so channel 0 has first priority.
//     - in_ready = 0 while reset is asserted.
//   Load condition:
//     - load = !out_valid || out_ready.
//     - The register is empty, or it is being drained this cycle.
//   Grant (combinational, only when load = 1):
//     - Fixed mode: g = select.
//       Grant only if select < CHANNELS and in_valid[select] = 1.
//     - RR mode: g = first k with in_valid[k] = 1, searching from (last+1) mod CHANNELS
//       upward with wrap-around.
//       No grant if in_valid == 0.
//   Outputs and state:
//     - in_ready[g] = 1 for the granted channel only; every other bit is 0.
//     - A transfer on channel g happens on a clock edge with in_valid[g] && in_ready[g].
//       That edge loads out_data = in_data[g], out_chan = g, out_valid = 1.
//     - In RR mode, last is updated to g on the same edge. In fixed mode, last is unchanged.
//   Latency:
//     - 1 cycle from input transfer to out_valid.
//     - Full throughput: one word per cycle while out_ready = 1.
//   Backpressure:
//     - While out_valid && !out_ready, out_data and out_chan hold stable.
//     - All in_ready bits are 0 during this time.
//   Drain with no grant:
//     - out_valid && out_ready with no granted input: out_valid <= 0 and out_data holds.
//   Simultaneous drain and load:
//     - The new word replaces the old one. out_valid stays 1 with no bubble.
//   Mode or select change:
//     - Sampled combinationally each cycle.
//     - Affects only the next grant, never a word already held in out_data.
//   Reset mid-transfer:
//     - The held word is discarded and the producer's word is not accepted.
//     - The producer re-presents it after reset.
//   Fairness:
//     - In RR mode with all channels valid and out_ready = 1, grants run 0,1,2,...,CHANNELS-1,0.
//     - No channel waits more than CHANNELS-1 grants.
// TESTING
//   1. Reset:
//      - Stimulus: rst_n = 0 with random inputs.
//      - Response: out_valid = 0, out_data = 0, in_ready = 0. After release with
//        in_valid = 0, out_valid stays 0.
//   2. Fixed mode:
//      - Stimulus: rr_en = 0, select = 3, ch3 = 16'h9FFF valid, all channels valid.
//      - Response: in_ready = 4'b1000. Next cycle out_data = 16'h9FFF, out_chan = 3.
//   3. Round robin:
//      - Stimulus: rr_en = 1, all four channels valid with 16'hFFFF/DFFF/BFFF/9FFF,
//        out_ready = 1.
//      - Response: out_chan sequence 0,1,2,3,0 on consecutive cycles with matching data.
//   4. Backpressure:
//      - Stimulus: out_ready = 0 for 3 cycles while holding 16'hDFFF.
//      - Response: out_data and out_chan are stable and in_ready = 0.
//        On release, the next word follows with no bubble.
//   5. RR skip and wrap:
//      - Stimulus: last = 2, in_valid = 4'b0011.
//      - Response: grant ch0, then ch1, then ch0.
//        Fixed select = 2 with in_valid[2] = 0 gives no grant and out_valid = 0 after drain.
//   6. Asynchronous reset mid-stream:
//      - Stimulus: rst_n pulsed low between clock edges while out_valid = 1.
//      - Response: out_valid = 0 immediately. The next RR grant after release goes to ch0.

Source files
------------

// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: mode/select control, N producer channels
// and one registered consumer output. The slave view belongs to the mux; the
// master view belongs to whatever drives the producers and the consumer.
interface rr_mux_reg_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic                      rr_en;
    logic [SEL_W-1:0]          select;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  rr_en,
        input  select,
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid
    );

    modport master (
        output rr_en,
        output select,
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid
    );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel, W-bit registered multiplexer with valid/ready
// handshake. In fixed mode the select input picks the channel; in round-robin
// mode the grant rotates starting just after the last channel served. A single
// output register feeds one consumer; it reloads whenever it is empty or
// being drained, so a steady stream moves one word per cycle with no bubbles.
module rr_mux_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_reg_if.slave  bus
);

    // Output register and round-robin pointer
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]    last_q,      last_d;

    // Grant path
    logic                load;
    logic                fixed_hit;
    logic                rr_hit;
    logic [SEL_W-1:0]    rr_idx;
    logic [SEL_W-1:0]    rr_cand [CHANNELS];
    logic                grant_valid;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic [CHANNELS-1:0] grant_onehot;

    // The register may take a new word when it is empty or its word leaves now.
    assign load = !out_valid_q || bus.out_ready;

    // Candidate k is the channel k+1 places after the last one served, so
    // candidate 0 is the highest-priority channel this cycle.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_cand
        assign rr_cand[k] = SEL_W'((int'(last_q) + k + 1) % CHANNELS);
    end

    // Fixed mode grants only an in-range select whose channel has data.
    always_comb begin
        fixed_hit = 1'b0;
        if (int'(bus.select) < CHANNELS) begin
            fixed_hit = bus.in_valid[bus.select];
        end
    end

    // Round-robin search; scanning from the lowest priority upward lets the
    // last match found be the highest-priority valid channel.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (bus.in_valid[rr_cand[k]]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand[k];
            end
        end
    end

    // Pick the grant for this cycle; nothing is granted in reset or while the
    // register is stalled by the consumer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (rst_n && load) begin
            if (bus.rr_en) begin
                grant_valid = rr_hit;
                grant_idx   = rr_idx;
            end else begin
                grant_valid = fixed_hit;
                grant_idx   = bus.select;
            end
        end
    end

    // Only the granted producer sees ready.
    always_comb begin
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign grant_data   = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign bus.in_ready = grant_onehot;

    // Next state: a grant is always a transfer (the granted channel is valid),
    // and it overrides a simultaneous drain so the stream has no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        if (grant_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            if (bus.rr_en) begin
                last_d = grant_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register; reset leaves the pointer on the last channel so channel
    // 0 wins the first round-robin grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            last_q      <= last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

    // At most one producer may be told ready in any cycle.
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.in_ready));

    // A stalled word must not move until the consumer takes it.
    assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=>
        (out_valid_q && $stable(out_data_q) && $stable(out_chan_q)));

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed testbench for rr_mux_reg: expected words go into a scoreboard queue
// as stimulus is issued; a monitor pops and compares on every accepted output.
module tb_rr_mux_reg;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] chan;
    } expWord_t;

    logic clk;
    logic rst_n;

    int vectorCount = 0;
    int missCount   = 0;

    expWord_t sbQueue[$];
    expWord_t monWord;

    rr_mux_reg_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

    rr_mux_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [CHANNELS-1:0] valid, input logic rr,
                                 input logic [SEL_W-1:0] sel, input logic ready);
        bus.in_valid  = valid;
        bus.rr_en     = rr;
        bus.select    = sel;
        bus.out_ready = ready;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pushExp(input logic [WIDTH-1:0] data, input logic [SEL_W-1:0] chan);
        expWord_t w;
        w.data = data;
        w.chan = chan;
        sbQueue.push_back(w);
    endtask

    // Monitor: every word the consumer accepts must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbQueue.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL sb_unexpected: got data %h chan %0d, expected no word",
                         bus.out_data, bus.out_chan);
            end else begin
                monWord = sbQueue.pop_front();
                checkOutput("sb_data", 32'(bus.out_data), 32'(monWord.data));
                checkOutput("sb_chan", 32'(bus.out_chan), 32'(monWord.chan));
            end
        end
    end

    initial begin
        logic [SEL_W-1:0] rrSeq3 [5];
        logic [SEL_W-1:0] rrSeq5 [3];
        logic [WIDTH-1:0] chData [CHANNELS];

        chData[0] = 16'hFFFF;
        chData[1] = 16'hDFFF;
        chData[2] = 16'hBFFF;
        chData[3] = 16'h9FFF;
        rrSeq3[0] = 2'd0; rrSeq3[1] = 2'd1; rrSeq3[2] = 2'd2; rrSeq3[3] = 2'd3; rrSeq3[4] = 2'd0;
        rrSeq5[0] = 2'd0; rrSeq5[1] = 2'd1; rrSeq5[2] = 2'd0;

        // Reset with random inputs
        rst_n       = 1'b0;
        bus.in_data = {$urandom, $urandom};
        applyStimulus(4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
        repeat (2) step();
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
        checkOutput("rst_out_chan",  32'(bus.out_chan),  32'd0);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
        step();
        applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("post_rst_idle", 32'(bus.out_valid), 32'd0);
            step();
        end

        // Fixed mode, select 3 with every channel valid
        for (int k = 0; k < CHANNELS; k++) bus.in_data[k*WIDTH +: WIDTH] = chData[k];
        applyStimulus(4'b1111, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        checkOutput("fixed_in_ready", 32'(bus.in_ready), 32'h8);
        pushExp(16'h9FFF, 2'd3);
        step();
        applyStimulus(4'b0000, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        checkOutput("fixed_idle_ready", 32'(bus.in_ready), 32'h0);
        step();
        @(negedge clk);
        checkOutput("fixed_drained", 32'(bus.out_valid), 32'd0);
        step();

        // Round robin over four valid channels
        applyStimulus(4'b1111, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rr_in_ready", 32'(bus.in_ready), 32'(4'b0001 << rrSeq3[i]));
            pushExp(chData[rrSeq3[i]], rrSeq3[i]);
            step();
        end
        applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
        @(negedge clk);
        step();

        // Backpressure: hold DFFF on channel 1 for three cycles
        applyStimulus(4'b1111, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("bp_first_grant", 32'(bus.in_ready), 32'h2);
        pushExp(16'hDFFF, 2'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_valid",    32'(bus.out_valid), 32'd1);
            checkOutput("bp_data",     32'(bus.out_data),  32'h0000DFFF);
            checkOutput("bp_chan",     32'(bus.out_chan),  32'd1);
            checkOutput("bp_in_ready", 32'(bus.in_ready),  32'h0);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_grant", 32'(bus.in_ready), 32'h4);
        pushExp(16'hBFFF, 2'd2);
        step();
        applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
        @(negedge clk);
        checkOutput("bp_no_bubble", 32'(bus.out_valid), 32'd1);
        step();

        // Round-robin skip and wrap from pointer 2 with channels 0 and 1 valid
        applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("skip_in_ready", 32'(bus.in_ready), 32'(4'b0001 << rrSeq5[i]));
            pushExp(chData[rrSeq5[i]], rrSeq5[i]);
            step();
        end
        applyStimulus(4'b0011, 1'b0, 2'd2, 1'b1);
        @(negedge clk);
        checkOutput("fixed_invalid_sel", 32'(bus.in_ready), 32'h0);
        step();
        @(negedge clk);
        checkOutput("fixed_invalid_drain", 32'(bus.out_valid), 32'd0);
        step();

        // Asynchronous reset while a word is held
        applyStimulus(4'b1111, 1'b1, 2'd0, 1'b0);
        step();
        @(negedge clk);
        checkOutput("mid_held_valid", 32'(bus.out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid",    32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_data",     32'(bus.out_data),  32'd0);
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready),  32'h0);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        pushExp(16'hFFFF, 2'd0);
        #1;
        checkOutput("mid_rst_first_grant", 32'(bus.in_ready), 32'h1);
        step();
        applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
        repeat (3) step();

        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
